// File: rtl/mac_header_tx.sv
// Frame source: 3-word destination MAC header then len payload words; optional stats under MAC_HDR_TX_STATS_EN.
// Latency: first header word one cycle after cmd accept; holds words under tx_tready=0, payload passes straight through.
module mac_header_tx #(
   parameter int          LEN_W  = 16,
   parameter logic [15:0] MAC_W0 = 16'h0A00,
   parameter logic [15:0] MAC_W1 = 16'h1234,
   parameter logic [15:0] MAC_W2 = 16'h5670
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_dest,
   input  logic             cmd_invalid,
   input  logic [LEN_W-1:0] cmd_len,
   input  logic [15:0]      pay_tdata,
   input  logic             pay_tvalid,
   output logic             pay_tready,
   output logic [15:0]      tx_tdata,
   output logic             tx_tvalid,
   input  logic             tx_tready,
   output logic             tx_tlast,
   output logic             busy
`ifdef MAC_HDR_TX_STATS_EN
   ,
   output logic [15:0]      stat_frames,
   output logic [15:0]      stat_invalid
`endif
);

   typedef enum logic [2:0] {ST_IDLE, ST_HDR0, ST_HDR1, ST_HDR2, ST_PAYLOAD} state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [1:0]       dest_q, dest_d;
   logic             inv_q, inv_d;

   always_comb begin
      state_d    = state_q;
      len_cnt_d  = len_cnt_q;
      len_d      = len_q;
      dest_d     = dest_q;
      inv_d      = inv_q;
      cmd_ready  = 1'b0;
      pay_tready = 1'b0;
      tx_tvalid  = 1'b0;
      tx_tlast   = 1'b0;
      tx_tdata   = 16'h0000;
      busy       = 1'b1;
      case (state_q)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               dest_d  = cmd_dest;
               inv_d   = cmd_invalid;
               len_d   = cmd_len;
               state_d = ST_HDR0;
            end
         end
         ST_HDR0: begin
            tx_tvalid = 1'b1;
            // Top two bits carry the invalid marker only when commanded, never from the template.
            tx_tdata  = {(inv_q ? 2'b11 : 2'b00), MAC_W0[13:0]};
            if (tx_tready) state_d = ST_HDR1;
         end
         ST_HDR1: begin
            tx_tvalid = 1'b1;
            tx_tdata  = MAC_W1;
            if (tx_tready) state_d = ST_HDR2;
         end
         ST_HDR2: begin
            tx_tvalid = 1'b1;
            tx_tdata  = {MAC_W2[15:2], dest_q};
            tx_tlast  = (len_q == '0);
            if (tx_tready) begin
               if (len_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  len_cnt_d = len_q;
                  state_d   = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            tx_tdata   = pay_tdata;
            tx_tvalid  = pay_tvalid;
            pay_tready = tx_tready;
            tx_tlast   = pay_tvalid && (len_cnt_q == LEN_W'(1));
            if (pay_tvalid && tx_tready) begin
               len_cnt_d = len_cnt_q - LEN_W'(1);
               if (len_cnt_q == LEN_W'(1)) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         len_cnt_q <= '0;
         len_q     <= '0;
         dest_q    <= 2'b00;
         inv_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_cnt_q <= len_cnt_d;
         len_q     <= len_d;
         dest_q    <= dest_d;
         inv_q     <= inv_d;
      end
   end

`ifdef MAC_HDR_TX_STATS_EN
   logic [15:0] stat_frames_q, stat_frames_d;
   logic [15:0] stat_invalid_q, stat_invalid_d;
   logic        frame_done;

   always_comb begin
      frame_done     = tx_tvalid && tx_tready && tx_tlast;
      stat_frames_d  = stat_frames_q;
      stat_invalid_d = stat_invalid_q;
      if (frame_done && (stat_frames_q != 16'hFFFF)) stat_frames_d = stat_frames_q + 16'h0001;
      if (frame_done && inv_q && (stat_invalid_q != 16'hFFFF)) stat_invalid_d = stat_invalid_q + 16'h0001;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_frames_q  <= 16'h0000;
         stat_invalid_q <= 16'h0000;
      end else begin
         stat_frames_q  <= stat_frames_d;
         stat_invalid_q <= stat_invalid_d;
      end
   end

   assign stat_frames  = stat_frames_q;
   assign stat_invalid = stat_invalid_q;
`endif

endmodule
